// File: rtl/axi_lite_apb_master.sv
// AXI4-Lite slave to APB master bridge stage: one transaction in flight, fair
// read/write alternation, optional PREADY timeout forcing SLVERR.
module axi_lite_apb_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int PRDATA_DLY = 1
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPT, RESP} state_e;

  state_e              state_q, state_d;
  logic                aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                w_full_q, w_full_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                ar_full_q, ar_full_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                cur_wr_q, cur_wr_d;
  logic                last_wr_q, last_wr_d;
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                arready_q, arready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic                wr_rdy, rd_rdy, grant_wr;
  logic [CNT_W-1:0]    to_cnt_inc;
  logic                timeout_hit;
  logic [1:0]          acc_resp;

  assign wr_rdy      = aw_full_q && w_full_q;
  assign rd_rdy      = ar_full_q;
  // Write wins unless a read is also waiting and the previous grant was a write.
  assign grant_wr    = wr_rdy && (!rd_rdy || !last_wr_q);
  assign to_cnt_inc  = to_cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && !PREADY && (to_cnt_inc == CNT_W'(TIMEOUT));
  assign acc_resp    = (PREADY && !PSLVERR) ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ar_full_d = ar_full_q;
    araddr_d  = araddr_q;
    cur_wr_d  = cur_wr_q;
    last_wr_d = last_wr_q;
    to_cnt_d  = to_cnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    // Ready flags are only ever high in IDLE, so acceptance is IDLE-only.
    if (AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (WVALID && wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    if (ARVALID && arready_q) begin
      ar_full_d = 1'b1;
      araddr_d  = ARADDR;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_rdy || rd_rdy) begin
          cur_wr_d = grant_wr;
          if (grant_wr && (wstrb_q != '1)) begin
            bresp_d  = RESP_SLVERR;
            bvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = grant_wr;
            paddr_d   = (grant_wr ? awaddr_q : araddr_q) & ALIGN_MASK;
            pwdata_d  = grant_wr ? wdata_q : '0;
            to_cnt_d  = '0;
            state_d   = SETUP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (!PREADY) begin
          to_cnt_d = to_cnt_inc;
        end
        if (PREADY || timeout_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (cur_wr_q) begin
            bresp_d  = acc_resp;
            bvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            rresp_d = acc_resp;
            if (!PREADY) begin
              rdata_d  = '0;
              rvalid_d = 1'b1;
              state_d  = RESP;
            end else if (PRDATA_DLY == 0) begin
              rdata_d  = PRDATA;
              rvalid_d = 1'b1;
              state_d  = RESP;
            end else begin
              state_d = CAPT;
            end
          end
        end
      end
      CAPT: begin
        rdata_d  = PRDATA;
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (bvalid_q && BREADY) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          last_wr_d = 1'b1;
          state_d   = IDLE;
        end else if (rvalid_q && RREADY) begin
          rvalid_d  = 1'b0;
          ar_full_d = 1'b0;
          last_wr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = (state_d == IDLE) && !aw_full_d;
    wready_d  = (state_d == IDLE) && !w_full_d;
    arready_d = (state_d == IDLE) && !ar_full_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ar_full_q <= 1'b0;
      araddr_q  <= '0;
      cur_wr_q  <= 1'b0;
      last_wr_q <= 1'b0;
      to_cnt_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ar_full_q <= ar_full_d;
      araddr_q  <= araddr_d;
      cur_wr_q  <= cur_wr_d;
      last_wr_q <= last_wr_d;
      to_cnt_q  <= to_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign ARREADY = arready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_axi_lite_apb_master.sv
// Bench for axi_lite_apb_master: directed scenarios plus random traffic against
// a word-array reference model and a behavioural APB register-file slave.
module tb_axi_lite_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic        AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, PADDR, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA = '0;
  logic        PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  axi_lite_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .PRDATA_DLY(1)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // APB register-file slave: cfg_waits wait states, optional error, or stuck low.
  logic [31:0] slv_mem [16] = '{default: '0};
  int unsigned acc_cnt   = 0;
  int unsigned cfg_waits = 0;
  logic        cfg_err   = 1'b0;
  logic        cfg_stuck = 1'b0;
  logic [31:0] last_paddr = '0, last_pwdata = '0;
  logic        last_pwrite = 1'b0;

  assign PREADY  = PSEL && PENABLE && !cfg_stuck && (acc_cnt >= cfg_waits);
  assign PSLVERR = PREADY && cfg_err;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PREADY) begin
      last_paddr  <= PADDR;
      last_pwdata <= PWDATA;
      last_pwrite <= PWRITE;
      if (PWRITE && !cfg_err) slv_mem[PADDR[5:2]] <= PWDATA;
      if (!PWRITE)            PRDATA <= slv_mem[PADDR[5:2]];
    end
  end

  // APB monitor: counts SETUP phases, ACCESS length, grant order, signal hold.
  int          setups = 0;
  int          acc_len = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_wr;
  logic        grants [$];

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      setups++;
      acc_len = 0;
      s_addr  = PADDR;
      s_wdata = PWDATA;
      s_wr    = PWRITE;
      grants.push_back(PWRITE);
    end else if (PSEL && PENABLE) begin
      acc_len++;
      check("apb_hold", {PADDR, PWDATA, 31'd0, PWRITE}, {s_addr, s_wdata, 31'd0, s_wr});
    end
  end

  logic [31:0] ref_mem [16] = '{default: '0};

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int bdly, output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    while (!(aw_done && w_done) && c < 50) begin
      AWADDR  = addr;
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = !aw_done && (c >= w_lead);
      WVALID  = !w_done;
      aw_hs   = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      @(posedge PCLK);
      c++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      @(negedge PCLK);
    end
    AWVALID = 0;
    WVALID  = 0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    lat = 0;
    while (!BVALID && lat < 100) begin
      @(posedge PCLK);
      lat++;
      @(negedge PCLK);
    end
    check("bvalid_seen", BVALID, 1'b1);
    repeat (bdly) @(negedge PCLK);
    resp   = BRESP;
    BREADY = 1;
    @(posedge PCLK);
    @(negedge PCLK);
    BREADY = 0;
    check("bvalid_clr", BVALID, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdly,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit done = 0, hs;
    int c = 0;
    while (!done && c < 50) begin
      ARADDR  = addr;
      ARVALID = 1;
      hs      = ARREADY;
      @(posedge PCLK);
      c++;
      done = hs;
      @(negedge PCLK);
    end
    ARVALID = 0;
    check("ar_accept", done, 1'b1);
    lat = 0;
    while (!RVALID && lat < 100) begin
      @(posedge PCLK);
      lat++;
      @(negedge PCLK);
    end
    check("rvalid_seen", RVALID, 1'b1);
    repeat (rdly) @(negedge PCLK);
    data   = RDATA;
    resp   = RRESP;
    RREADY = 1;
    @(posedge PCLK);
    @(negedge PCLK);
    RREADY = 0;
    check("rvalid_clr", RVALID, 1'b0);
  endtask

  task automatic do_dual(input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr,
                         output logic [1:0] bresp, output logic [1:0] rresp, output logic [31:0] rdata);
    bit bg = 0, rg = 0;
    int c = 0;
    grants.delete();
    check("dual_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    AWADDR = waddr; WDATA = wdata; WSTRB = 4'hF; ARADDR = raddr;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    @(posedge PCLK);
    @(negedge PCLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    BREADY = 1; RREADY = 1;
    while (!(bg && rg) && c < 100) begin
      if (BVALID) begin bresp = BRESP; bg = 1; end
      if (RVALID) begin rdata = RDATA; rresp = RRESP; rg = 1; end
      @(posedge PCLK);
      c++;
      @(negedge PCLK);
    end
    BREADY = 0; RREADY = 0;
    check("dual_done", {bg, rg}, 2'b11);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {AWREADY, WREADY, ARREADY, BVALID, RVALID, PSEL, PENABLE, PWRITE, BRESP, RRESP}, '0);
    check({tag, "_data"}, {PADDR, PWDATA, RDATA}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, addr, data;
    logic [1:0]  rs, bs, exp_rs;
    logic [3:0]  strb;
    int          lat, s0, idx, w, c;
    logic        err;

    PRESETn = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
    #1 PRESETn = 0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge PCLK);
    PRESETn = 1;
    repeat (2) @(negedge PCLK);
    check("idle_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Both pending after reset: write first, then read; repeat keeps alternating.
    do_dual(32'h20, 32'hA5A5_0001, 32'h24, bs, rs, rd);
    ref_mem[8] = 32'hA5A5_0001;
    check("gnt_a_n", grants.size(), 2);
    check("gnt_a", {grants[0], grants[1]}, 2'b10);
    check("dual_a_resp", {bs, rs, rd}, {2'b00, 2'b00, ref_mem[9]});
    do_dual(32'h28, 32'hA5A5_0002, 32'h20, bs, rs, rd);
    ref_mem[10] = 32'hA5A5_0002;
    check("gnt_b", {grants[0], grants[1]}, 2'b10);
    check("dual_b_rdata", rd, ref_mem[8]);

    // Write 0x14 / DEADBEEF with a zero-wait slave, then read it back.
    s0 = setups;
    do_write(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, rs, lat);
    ref_mem[5] = 32'hDEAD_BEEF;
    check("t1_bresp", rs, 2'b00);
    check("t1_lat", lat, 3);
    check("t1_setups", setups - s0, 1);
    check("t1_acc_len", acc_len, 1);
    check("t1_paddr", {last_pwrite, last_paddr, last_pwdata}, {1'b1, 32'h14, 32'hDEAD_BEEF});
    do_read(32'h14, 1, rd, rs, lat);
    check("t1_rdata", rd, 32'hDEAD_BEEF);
    check("t1_rresp", rs, 2'b00);
    check("t1_rlat", lat, 4);

    // Last grant a read then a write: with both pending the read goes first.
    do_write(32'h30, 32'h0000_0C0C, 4'hF, 0, 0, rs, lat);
    ref_mem[12] = 32'h0000_0C0C;
    do_dual(32'h34, 32'h1234_5678, 32'h30, bs, rs, rd);
    ref_mem[13] = 32'h1234_5678;
    check("gnt_c", {grants[0], grants[1]}, 2'b01);
    check("dual_c_rdata", rd, ref_mem[12]);

    // Three wait states then PSLVERR.
    cfg_waits = 3; cfg_err = 1;
    do_write(32'h18, 32'h5555_AAAA, 4'hF, 0, 2, rs, lat);
    cfg_waits = 0; cfg_err = 0;
    check("t3_bresp", rs, 2'b10);
    check("t3_acc_len", acc_len, 4);
    check("t3_lat", lat, 6);

    // Hung slave on a read: timeout after 16 ACCESS cycles.
    cfg_stuck = 1;
    do_read(32'h14, 0, rd, rs, lat);
    cfg_stuck = 0;
    check("t4_acc_len", acc_len, 16);
    check("t4_resp", {rs, rd}, {2'b10, 32'h0});
    check("t4_lat", lat, 18);

    // Partial strobes: no APB transfer.
    s0 = setups;
    do_write(32'h14, 32'h0BAD_0BAD, 4'b0011, 0, 0, rs, lat);
    check("t5_bresp", rs, 2'b10);
    check("t5_nosetup", setups - s0, 0);
    check("t5_lat", lat, 1);
    // W leads AW by two cycles.
    do_write(32'h3C, 32'hCAFE_F00D, 4'hF, 2, 0, rs, lat);
    ref_mem[15] = 32'hCAFE_F00D;
    check("t5_lead_resp", rs, 2'b00);
    check("t5_lead_lat", lat, 3);
    check("t5_lead_mem", slv_mem[15], 32'hCAFE_F00D);

    // Reset asserted mid-ACCESS aborts the write.
    cfg_stuck = 1;
    AWADDR = 32'h14; WDATA = 32'hFFFF_0000; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(posedge PCLK);
    @(negedge PCLK);
    AWVALID = 0; WVALID = 0;
    c = 0;
    while (!(PSEL && PENABLE) && c < 20) begin
      @(negedge PCLK);
      c++;
    end
    check("t6_in_access", PSEL && PENABLE, 1'b1);
    #2 PRESETn = 0;
    #1 check_outputs_zero("t6_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("t6_no_bvalid", {BVALID, PSEL}, 2'b00);
    end
    PRESETn = 1;
    cfg_stuck = 0;
    repeat (2) @(negedge PCLK);
    check("t6_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    do_read(32'h14, 0, rd, rs, lat);
    check("t6_rdata", {rs, rd}, {2'b00, ref_mem[5]});
    check("t6_rlat", lat, 4);

    // Random traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      idx  = $urandom_range(0, 15);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      w    = $urandom_range(0, 3);
      err  = ($urandom_range(0, 5) == 0);
      cfg_waits = w;
      cfg_err   = err;
      exp_rs    = err ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        s0   = setups;
        do_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), rs, lat);
        if (strb != 4'hF) begin
          check("rnd_strb_resp", {rs, 8'(lat), 8'(setups - s0)}, {2'b10, 8'd1, 8'd0});
        end else begin
          check("rnd_wr_resp", rs, exp_rs);
          check("rnd_wr_lat", lat, 3 + w);
          check("rnd_wr_apb", {last_pwrite, last_paddr, last_pwdata}, {1'b1, 32'(idx * 4), data});
          if (!err) ref_mem[idx] = data;
        end
      end else begin
        do_read(addr, $urandom_range(0, 2), rd, rs, lat);
        check("rnd_rd_data", rd, ref_mem[idx]);
        check("rnd_rd_resp", rs, exp_rs);
        check("rnd_rd_lat", lat, 4 + w);
        check("rnd_rd_apb", {last_pwrite, last_paddr}, {1'b0, 32'(idx * 4)});
      end
    end
    cfg_waits = 0;
    cfg_err   = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
